// File: rtl/lpc_residual_filter.sv
// LPC residual filter: loads quantized predictor coefficients, then emits one residual per sample
// through a 3-stage multiply / sum / shift-subtract pipeline. Optional macro: LPC_RESIDUAL_ZIGZAG_EN.
module lpc_residual_filter #(
  parameter int MAX_ORDER = 12
) (
  input  logic                iClock,
  input  logic                iReset,
  input  logic                iEnable,
  input  logic                iStart,
  input  logic [3:0]          iOrder,
  input  logic [3:0]          iShift,
  input  logic signed [11:0]  iCoeff,
  input  logic                iCoeffValid,
  input  logic                iCoeffDone,
  input  logic signed [15:0]  iSample,
  input  logic                iSampleValid,
  input  logic                iLastSample,
  output logic                oReady,
  output logic [23:0]         oResidual,
  output logic                oResidualValid,
  output logic                oWarmup,
  output logic                oFrameDone
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t state_reg, state_next;
  logic [3:0] order_reg, shift_reg, load_cnt_reg, sample_cnt_reg;
  logic [3:0] order_in;
  logic       start_accept, coeff_write, sample_accept;

  // Stage 1: per-tap products live in the tap blocks; these carry the sample alongside.
  logic               s1_valid_reg, s1_warm_reg, s1_last_reg;
  logic signed [15:0] s1_sample_reg;
  logic [3:0]         s1_shift_reg;
  // Stage 2: accumulated prediction sum.
  logic               s2_valid_reg, s2_warm_reg, s2_last_reg;
  logic signed [15:0] s2_sample_reg;
  logic [3:0]         s2_shift_reg;
  logic signed [31:0] s2_sum_reg;
  // Stage 3: output registers.
  logic [23:0]        res_reg;
  logic               res_valid_reg, warm_reg, done_reg;

  logic signed [31:0] pred;
  logic signed [32:0] diff;
  logic signed [23:0] sat;
  logic signed [23:0] res_signed;
  logic [23:0]        res_out;

  assign order_in = (iOrder > 4'(MAX_ORDER)) ? 4'd0 : iOrder;

  always_comb begin
    state_next    = state_reg;
    start_accept  = 1'b0;
    coeff_write   = 1'b0;
    sample_accept = 1'b0;
    case (state_reg)
      IDLE: begin
        if (iStart) begin
          start_accept = 1'b1;
          state_next   = (order_in == 4'd0) ? RUN : LOAD;
        end
      end
      LOAD: begin
        coeff_write = iCoeffValid;
        if (iCoeffDone || (iCoeffValid && (load_cnt_reg == order_reg - 4'd1)))
          state_next = RUN;
      end
      RUN: begin
        sample_accept = iSampleValid;
        if (iSampleValid && iLastSample)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Each tap holds its coefficient, its history word and its stage-1 product; the
  // partial sums chain across taps so stage 2 is a single registered adder tree.
  for (genvar gi = 0; gi < MAX_ORDER; gi++) begin : g_tap
    logic signed [11:0] coeff_reg;
    logic signed [15:0] hist_reg;
    logic signed [15:0] hist_in;
    logic signed [27:0] prod_reg;
    logic signed [31:0] psum;

    if (gi == 0) begin : g_first
      assign hist_in = iSample;
      assign psum    = 32'(prod_reg);
    end else begin : g_rest
      assign hist_in = g_tap[gi-1].hist_reg;
      assign psum    = g_tap[gi-1].psum + 32'(prod_reg);
    end

    always_ff @(posedge iClock) begin
      if (iReset) begin
        coeff_reg <= '0;
        hist_reg  <= '0;
        prod_reg  <= '0;
      end else if (iEnable) begin
        if (start_accept) begin
          coeff_reg <= '0;
          hist_reg  <= '0;
        end else begin
          if (coeff_write && (load_cnt_reg == 4'(gi)))
            coeff_reg <= iCoeff;
          if (sample_accept)
            hist_reg <= hist_in;
        end
        // Uses the history before this cycle's shift: h[0] is x[n-1] for the accepted x[n].
        prod_reg <= 28'(coeff_reg) * 28'(hist_reg);
      end
    end
  end

  always_comb begin
    pred = s2_sum_reg >>> s2_shift_reg;
    diff = 33'(s2_sample_reg) - 33'(pred);
    if (diff > 33'sd8388607)
      sat = 24'sh7FFFFF;
    else if (diff < -33'sd8388608)
      sat = 24'sh800000;
    else
      sat = diff[23:0];
    res_signed = s2_warm_reg ? 24'(s2_sample_reg) : sat;
`ifdef LPC_RESIDUAL_ZIGZAG_EN
    res_out = {res_signed[22:0], 1'b0} ^ {24{res_signed[23]}};
`else
    res_out = res_signed;
`endif
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_reg      <= IDLE;
      order_reg      <= '0;
      shift_reg      <= '0;
      load_cnt_reg   <= '0;
      sample_cnt_reg <= '0;
      s1_valid_reg   <= 1'b0;
      s1_warm_reg    <= 1'b0;
      s1_last_reg    <= 1'b0;
      s1_sample_reg  <= '0;
      s1_shift_reg   <= '0;
      s2_valid_reg   <= 1'b0;
      s2_warm_reg    <= 1'b0;
      s2_last_reg    <= 1'b0;
      s2_sample_reg  <= '0;
      s2_shift_reg   <= '0;
      s2_sum_reg     <= '0;
      res_reg        <= '0;
      res_valid_reg  <= 1'b0;
      warm_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else if (iEnable) begin
      state_reg <= state_next;
      if (start_accept) begin
        order_reg      <= order_in;
        shift_reg      <= iShift;
        load_cnt_reg   <= '0;
        sample_cnt_reg <= '0;
      end
      if (coeff_write)
        load_cnt_reg <= load_cnt_reg + 4'd1;
      if (sample_accept && (sample_cnt_reg != 4'd15))
        sample_cnt_reg <= sample_cnt_reg + 4'd1;

      // The shift travels with the sample so a new frame's start cannot alter draining residuals.
      s1_valid_reg  <= sample_accept;
      s1_warm_reg   <= (sample_cnt_reg < order_reg);
      s1_last_reg   <= sample_accept & iLastSample;
      s1_sample_reg <= iSample;
      s1_shift_reg  <= shift_reg;

      s2_valid_reg  <= s1_valid_reg;
      s2_warm_reg   <= s1_warm_reg;
      s2_last_reg   <= s1_last_reg;
      s2_sample_reg <= s1_sample_reg;
      s2_shift_reg  <= s1_shift_reg;
      s2_sum_reg    <= g_tap[MAX_ORDER-1].psum;

      res_valid_reg <= s2_valid_reg;
      warm_reg      <= s2_valid_reg & s2_warm_reg;
      done_reg      <= s2_valid_reg & s2_last_reg;
      if (s2_valid_reg)
        res_reg <= res_out;
    end
  end

  assign oReady         = (state_reg == RUN);
  assign oResidual      = res_reg;
  assign oResidualValid = res_valid_reg;
  assign oWarmup        = warm_reg;
  assign oFrameDone     = done_reg;

endmodule

// File: tb/tb_lpc_residual_filter.sv
// Self-checking bench for lpc_residual_filter: vector table driven into a scoreboard queue,
// plus hand sequences for enable stall and mid-frame reset.
module tb_lpc_residual_filter;

  logic               iClock = 1'b0;
  logic               iReset, iEnable, iStart;
  logic [3:0]         iOrder, iShift;
  logic signed [11:0] iCoeff;
  logic               iCoeffValid, iCoeffDone;
  logic signed [15:0] iSample;
  logic               iSampleValid, iLastSample;
  logic               oReady;
  logic [23:0]        oResidual;
  logic               oResidualValid, oWarmup, oFrameDone;

  lpc_residual_filter #(.MAX_ORDER(12)) dut (
    .iClock(iClock), .iReset(iReset), .iEnable(iEnable), .iStart(iStart),
    .iOrder(iOrder), .iShift(iShift), .iCoeff(iCoeff), .iCoeffValid(iCoeffValid),
    .iCoeffDone(iCoeffDone), .iSample(iSample), .iSampleValid(iSampleValid),
    .iLastSample(iLastSample), .oReady(oReady), .oResidual(oResidual),
    .oResidualValid(oResidualValid), .oWarmup(oWarmup), .oFrameDone(oFrameDone)
  );

  always #5 iClock = ~iClock;

  typedef struct {
    logic signed [15:0] sample;
    logic               last;
    logic signed [23:0] res;
    logic               warm;
  } vec_t;

  typedef struct {
    logic [23:0] res;
    logic        warm;
    logic        last;
    int          acc_en;
  } exp_t;

  vec_t vec [20];
  exp_t sb [$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_out = 0;
  int   en_cnt = 0;
  bit   en_seen = 1'b0;

  function automatic logic [23:0] zz(input logic signed [23:0] r);
    int v;
    v = r;
    return (v >= 0) ? 24'(2 * v) : 24'(-2 * v - 1);
  endfunction

  always @(posedge iClock) begin
    en_seen = iEnable;
    if (iEnable) en_cnt++;
  end

  always @(negedge iClock) begin
    exp_t e;
    if (en_seen && (oResidualValid || oFrameDone)) begin
      n_out++;
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_output: got res=%0d valid=%0b done=%0b, required none",
                 oResidual, oResidualValid, oFrameDone);
      end else begin
        e = sb.pop_front();
        if (oResidualValid !== 1'b1 || oResidual !== e.res || oWarmup !== e.warm ||
            oFrameDone !== e.last || (en_cnt - e.acc_en) != 2) begin
          n_err++;
          $display("FAIL residual: got res=%0h warm=%0b done=%0b lat=%0d, required res=%0h warm=%0b done=%0b lat=2",
                   oResidual, oWarmup, oFrameDone, en_cnt - e.acc_en, e.res, e.warm, e.last);
        end else begin
          $display("residual %0h warm=%0b done=%0b ok", oResidual, oWarmup, oFrameDone);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end else begin
      $display("%s ok (%0h)", name, act);
    end
  endtask

  task automatic step();
    @(posedge iClock);
    #1;
  endtask

  task automatic start(input logic [3:0] order, input logic [3:0] shift);
    iStart = 1'b1; iOrder = order; iShift = shift;
    step();
    iStart = 1'b0;
  endtask

  task automatic send_coeff(input logic signed [11:0] c);
    iCoeffValid = 1'b1; iCoeff = c;
    step();
    iCoeffValid = 1'b0;
  endtask

  task automatic drive_sample(input vec_t v);
    exp_t e;
    iSample = v.sample; iSampleValid = 1'b1; iLastSample = v.last;
    step();
    iSampleValid = 1'b0; iLastSample = 1'b0;
`ifdef LPC_RESIDUAL_ZIGZAG_EN
    e.res = zz(v.res);
`else
    e.res = v.res;
`endif
    e.warm   = v.warm;
    e.last   = v.last;
    e.acc_en = en_cnt;
    sb.push_back(e);
  endtask

  task automatic run_vecs(input int first, input int count);
    for (int i = first; i < first + count; i++) drive_sample(vec[i]);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 40) begin
      step();
      t++;
    end
    check("drain_queue_empty", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    logic [23:0] held_res;
    logic        held_valid;
    int          out_snap;

    vec[0]  = '{16'sd5,      1'b0, 24'sd5,        1'b0};
    vec[1]  = '{-16'sd3,     1'b0, -24'sd3,       1'b0};
    vec[2]  = '{16'sd7,      1'b1, 24'sd7,        1'b0};
    vec[3]  = '{16'sd10,     1'b0, 24'sd10,       1'b1};
    vec[4]  = '{16'sd20,     1'b0, 24'sd20,       1'b1};
    vec[5]  = '{16'sd30,     1'b0, 24'sd0,        1'b0};
    vec[6]  = '{16'sd50,     1'b1, 24'sd10,       1'b0};
    vec[7]  = '{-16'sd5,     1'b0, -24'sd5,       1'b1};
    vec[8]  = '{16'sd0,      1'b1, 24'sd8,        1'b0};
    vec[9]  = '{16'sd10,     1'b0, 24'sd10,       1'b1};
    vec[10] = '{16'sd20,     1'b0, 24'sd20,       1'b1};
    vec[11] = '{16'sd30,     1'b0, 24'sd30,       1'b1};
    vec[12] = '{16'sd50,     1'b0, 24'sd50,       1'b1};
    vec[13] = '{16'sd80,     1'b1, 24'sd10,       1'b0};
    vec[14] = '{16'sd100,    1'b0, 24'sd100,      1'b0};
    vec[15] = '{-16'sd100,   1'b1, -24'sd100,     1'b0};
    vec[16] = '{16'sd32767,  1'b0, 24'sd32767,    1'b1};
    vec[17] = '{-16'sd32768, 1'b1, -24'sd8388608, 1'b0};
    vec[18] = '{16'sd1,      1'b0, 24'sd1,        1'b0};
    vec[19] = '{-16'sd1,     1'b1, -24'sd1,       1'b0};

    iReset = 1'b1; iEnable = 1'b1; iStart = 1'b0; iOrder = '0; iShift = '0;
    iCoeff = '0; iCoeffValid = 1'b0; iCoeffDone = 1'b0;
    iSample = '0; iSampleValid = 1'b0; iLastSample = 1'b0;
    repeat (3) step();
    check("reset_outputs", {4'd0, oReady, oResidualValid, oWarmup, oFrameDone, oResidual}, 32'd0);
    iReset = 1'b0;
    step();

    // Order 0 pass-through
    start(4'd0, 4'd0);
    check("ready_order0", oReady, 1);
    run_vecs(0, 3);
    drain();

    // Order 2, shift 0; samples offered during LOAD must be ignored
    start(4'd2, 4'd0);
    check("ready_in_load", oReady, 0);
    iSample = 16'sd999; iSampleValid = 1'b1;
    send_coeff(12'sd2);
    send_coeff(-12'sd1);
    iSampleValid = 1'b0;
    check("ready_after_load", oReady, 1);
    run_vecs(3, 4);
    drain();

    // Shift with negative rounding
    start(4'd1, 4'd1);
    send_coeff(12'sd3);
    run_vecs(7, 2);
    drain();

    // Early done: order 4 with two coefficients
    start(4'd4, 4'd0);
    send_coeff(12'sd2);
    send_coeff(-12'sd1);
    check("ready_before_done", oReady, 0);
    iCoeffDone = 1'b1;
    step();
    iCoeffDone = 1'b0;
    check("ready_after_done", oReady, 1);
    run_vecs(9, 5);
    drain();

    // Out-of-range order behaves as order 0
    start(4'd13, 4'd0);
    check("ready_order13", oReady, 1);
    run_vecs(14, 2);
    drain();

    // Saturation with a two-cycle enable stall mid-pipeline
    start(4'd1, 4'd0);
    send_coeff(12'sd2047);
    run_vecs(16, 2);
    held_res = oResidual; held_valid = oResidualValid;
    iEnable = 1'b0;
    step();
    step();
    check("stall_hold", {7'd0, oResidualValid, oResidual}, {7'd0, held_valid, held_res});
    iEnable = 1'b1;
    drain();

    // Reset with two samples in flight
    start(4'd0, 4'd0);
    iSample = 16'sd11; iSampleValid = 1'b1;
    step();
    iSample = 16'sd12;
    step();
    iSampleValid = 1'b0;
    out_snap = n_out;
    iReset = 1'b1;
    step();
    iReset = 1'b0;
    check("reset_to_idle", oReady, 0);
    repeat (5) step();
    check("no_output_after_reset", n_out, out_snap);
    start(4'd0, 4'd0);
    check("ready_after_reset", oReady, 1);
    run_vecs(18, 2);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

endmodule
